// File: rtl/cesa_recovery_unit_pkg.sv
// rtl/cesa_recovery_unit_pkg.sv - shared types and constants for the CESA recovery unit
package cesa_recovery_unit_pkg;
   localparam int CESA_BLK_W = 8;
   localparam int CESA_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } cesa_state_e;
endpackage

// File: rtl/block8.sv
// rtl/block8.sv - 8-bit speculative adder block; cout estimated from the upper nibble only
module block8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout_est
);
   logic [3:0] g;
   logic [3:0] p;

   assign sum = a + b + {7'd0, cin};
   assign g   = a[7:4] & b[7:4];
   assign p   = a[7:4] ^ b[7:4];

   // Carry into bit 4 is assumed zero, so a carry rippling up from the low nibble is missed
   assign cout_est = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
endmodule

// File: rtl/cesa_blk_chk.sv
// rtl/cesa_blk_chk.sv - exact 8-bit ripple carry of one block from its speculative carry in
module cesa_blk_chk (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic       cout
);
   logic c;

   always_comb begin
      c = cin;
      for (int i = 0; i < 8; i++) begin
         c = (a[i] & b[i]) | ((a[i] ^ b[i]) & c);
      end
   end

   assign cout = c;
endmodule

// File: rtl/cesa_recovery_unit.sv
// rtl/cesa_recovery_unit.sv - carry-estimating speculative adder with one-cycle exact recovery
// Optional error counter output err_cnt_o enabled by CESA_ERR_COUNT_EN.
module cesa_recovery_unit
   import cesa_recovery_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
`ifdef CESA_ERR_COUNT_EN
   output logic [CESA_CNT_W-1:0] err_cnt_o,
`endif
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [WIDTH-1:0]      a_i,
   input  logic [WIDTH-1:0]      b_i,
   input  logic                  cin_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [WIDTH-1:0]      sum_o,
   output logic                  cout_o,
   output logic                  spec_err_o
);
   localparam int NBLK = WIDTH / CESA_BLK_W;

   cesa_state_e      state;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic             cin_r;
   logic [NBLK:0]    c;
   logic [NBLK-1:0]  err;
   logic [WIDTH-1:0] spec_sum;
   logic [WIDTH:0]   exact;
   logic             accept;

   assign c[0] = cin_r;

   generate
      for (genvar k = 0; k < NBLK; k++) begin : g_blk
         logic chk_c;

         block8 u_b8 (
            .a        (a_r[k*CESA_BLK_W +: CESA_BLK_W]),
            .b        (b_r[k*CESA_BLK_W +: CESA_BLK_W]),
            .cin      (c[k]),
            .sum      (spec_sum[k*CESA_BLK_W +: CESA_BLK_W]),
            .cout_est (c[k+1])
         );

         cesa_blk_chk u_chk (
            .a    (a_r[k*CESA_BLK_W +: CESA_BLK_W]),
            .b    (b_r[k*CESA_BLK_W +: CESA_BLK_W]),
            .cin  (c[k]),
            .cout (chk_c)
         );

         assign err[k] = chk_c ^ c[k+1];
      end
   endgenerate

   // Operands stay stable from EVAL through FIX, so this adder is a 2-cycle path
   assign exact  = {1'b0, a_r} + {1'b0, b_r} + {{WIDTH{1'b0}}, cin_r};
   assign ready_o = (state == IDLE) | ((state == DONE) & ready_i);
   assign accept  = valid_i & ready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= IDLE;
         a_r        <= '0;
         b_r        <= '0;
         cin_r      <= 1'b0;
         valid_o    <= 1'b0;
         sum_o      <= '0;
         cout_o     <= 1'b0;
         spec_err_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  a_r   <= a_i;
                  b_r   <= b_i;
                  cin_r <= cin_i;
                  state <= EVAL;
               end
            end
            EVAL: begin
               // All local checks clean means every block cin was exact
               if (|err) begin
                  state <= FIX;
               end else begin
                  sum_o      <= spec_sum;
                  cout_o     <= c[NBLK];
                  spec_err_o <= 1'b0;
                  valid_o    <= 1'b1;
                  state      <= DONE;
               end
            end
            FIX: begin
               sum_o      <= exact[WIDTH-1:0];
               cout_o     <= exact[WIDTH];
               spec_err_o <= 1'b1;
               valid_o    <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               if (ready_i) begin
                  valid_o <= 1'b0;
                  if (valid_i) begin
                     a_r   <= a_i;
                     b_r   <= b_i;
                     cin_r <= cin_i;
                     state <= EVAL;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef CESA_ERR_COUNT_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_cnt_o <= '0;
      end else if ((state == FIX) && (err_cnt_o != {CESA_CNT_W{1'b1}})) begin
         err_cnt_o <= err_cnt_o + 1'b1;
      end
   end
`endif
endmodule
